// File: rtl/pair_triple_pkg.sv
// pair_triple_pkg: shared FSM states, first-match constants and majority helper for the pattern generator.
package pair_triple_pkg;
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  localparam int PATS_PER_PASS = 4;
  localparam logic [2:0] FIRST_MATCH_HI = 3'd3;
  localparam logic [2:0] FIRST_MATCH_LO = 3'd0;
  function automatic logic maj3(input logic [2:0] p);
    return (p[0] & p[1]) | (p[0] & p[2]) | (p[1] & p[2]);
  endfunction
endpackage

// File: rtl/pair_triple_next_match.sv
// pair_triple_next_match: next 3-bit pattern above cur whose majority equals target; wraps to the first match.
module pair_triple_next_match
  import pair_triple_pkg::*;
(
  input  logic [2:0] cur,
  input  logic       target,
  output logic [2:0] next,
  output logic       wrap
);
  logic [2:0] c;
  always_comb begin
    next = target ? FIRST_MATCH_HI : FIRST_MATCH_LO;
    wrap = 1'b1;
    c = cur;
    // descending scan so the smallest qualifying increment is the one that sticks
    for (int i = 7; i >= 1; i--) begin
      c = cur + 3'(i);
      if (c > cur && maj3(c) == target) begin
        next = c;
        wrap = 1'b0;
      end
    end
  end
endmodule

// File: rtl/pair_triple_pattern_gen.sv
// pair_triple_pattern_gen: streams every 3-bit pattern with the requested majority, NUM_PASSES times.
// Optional sticky err output under PAIR_TRIPLE_GEN_SELFCHECK_EN.
module pair_triple_pattern_gen
  import pair_triple_pkg::*;
#(
  parameter int NUM_PASSES = 2,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             target,
  output logic             busy,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [2:0]       out_pattern,
  output logic             done,
  output logic [CNT_W-1:0] count
`ifdef PAIR_TRIPLE_GEN_SELFCHECK_EN
  ,
  output logic             err
`endif
);
  state_t state, state_n;
  logic tgt, hs, wrap, last;
  logic [3:0] pass;
  logic [2:0] nxt;
  pair_triple_next_match u_next (.cur(out_pattern), .target(tgt), .next(nxt), .wrap(wrap));
  assign hs = out_val & out_rdy;
  assign last = hs & wrap & (pass == 4'(NUM_PASSES - 1));
  assign busy = state == EMIT;
  assign done = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (start ? EMIT : IDLE) : state == EMIT ? (last ? DONE : EMIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_val <= 1'b0;
      out_pattern <= 3'd0;
      count <= '0;
      pass <= 4'd0;
      tgt <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        tgt <= target;
        count <= '0;
        pass <= 4'd0;
        out_pattern <= target ? FIRST_MATCH_HI : FIRST_MATCH_LO;
        out_val <= 1'b1;
      end else if (hs) begin
        count <= &count ? count : count + 1'b1;
        out_pattern <= nxt;
        pass <= wrap ? pass + 4'd1 : pass;
        out_val <= ~last;
      end
    end
  end
`ifdef PAIR_TRIPLE_GEN_SELFCHECK_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) err <= 1'b0;
    else if (hs && maj3(out_pattern) != tgt) err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_pair_triple_pattern_gen.sv
// tb_pair_triple_pattern_gen: directed checks of ordering, stalls, reset, ignored starts and done pulse.
module tb_pair_triple_pattern_gen;
  import pair_triple_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, target = 1'b0, out_rdy = 1'b0;
  logic busy, out_val, done;
  logic [2:0] out_pattern;
  logic [5:0] count;
  int tests = 0, fails = 0;
  logic [2:0] seq_hi [4] = '{3'd3, 3'd5, 3'd6, 3'd7};
  logic [2:0] seq_lo [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
`ifdef PAIR_TRIPLE_GEN_SELFCHECK_EN
  logic err;
`endif
  pair_triple_pattern_gen #(.NUM_PASSES(2), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .busy(busy),
    .out_val(out_val), .out_rdy(out_rdy), .out_pattern(out_pattern),
    .done(done), .count(count)
`ifdef PAIR_TRIPLE_GEN_SELFCHECK_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // full request: toggle selects rdy pattern 1,0,0,...; inject pulses start mid-EMIT and in DONE
  task automatic run(input logic t, input bit toggle, input bit inject);
    int k = 0, cyc = 0;
    logic [2:0] exp;
    start = 1'b1;
    target = t;
    tick();
    start = 1'b0;
    check("busy_after_start", {7'd0, busy}, 8'd1);
    while (k < 2 * PATS_PER_PASS && cyc < 100) begin
      exp = t ? seq_hi[k % 4] : seq_lo[k % 4];
      out_rdy = toggle ? (cyc % 3 == 0) : 1'b1;
      start = inject && cyc == 3;
      target = inject && cyc == 3 ? ~t : t;
      check("val", {7'd0, out_val}, 8'd1);
      check("pattern", {5'd0, out_pattern}, {5'd0, exp});
      check("count_run", {2'd0, count}, 8'(k));
      if (out_rdy) k++;
      tick();
      cyc++;
    end
    start = 1'b0;
    out_rdy = 1'b0;
    check("handshakes_in_budget", 8'(k), 8'(2 * PATS_PER_PASS));
    check("done_pulse", {7'd0, done}, 8'd1);
    check("count_final", {2'd0, count}, 8'd8);
    check("val_done", {7'd0, out_val}, 8'd0);
    check("busy_done", {7'd0, busy}, 8'd0);
    start = inject;
    tick();
    start = 1'b0;
    check("done_once", {7'd0, done}, 8'd0);
    check("idle_val", {7'd0, out_val}, 8'd0);
    check("idle_busy", {7'd0, busy}, 8'd0);
    check("count_hold", {2'd0, count}, 8'd8);
`ifdef PAIR_TRIPLE_GEN_SELFCHECK_EN
    check("err_clean", {7'd0, err}, 8'd0);
`endif
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_val", {7'd0, out_val}, 8'd0);
    check("rst_pattern", {5'd0, out_pattern}, 8'd0);
    check("rst_count", {2'd0, count}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_done", {7'd0, done}, 8'd0);
    run(1'b1, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0);
    run(1'b1, 1'b0, 1'b1);
    // reset after three handshakes
    start = 1'b1;
    target = 1'b1;
    tick();
    start = 1'b0;
    out_rdy = 1'b1;
    tick();
    tick();
    tick();
    check("mid_pattern", {5'd0, out_pattern}, 8'd7);
    check("mid_count", {2'd0, count}, 8'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_rdy = 1'b0;
    check("midrst_val", {7'd0, out_val}, 8'd0);
    check("midrst_count", {2'd0, count}, 8'd0);
    check("midrst_busy", {7'd0, busy}, 8'd0);
    tick();
    check("midrst_idle", {7'd0, busy}, 8'd0);
    run(1'b1, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
